// File: rtl/rain_msg_formatter.sv
// Rain sample to ASCII line formatter: "R=<f>,V=<dddd>[*HH]\r\n" over a valid/ack byte stream.
// Optional checksum field enabled by defining RAIN_MSG_CHECKSUM_EN.
module rain_msg_formatter #(
  parameter int ADC_W    = 10,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic             rain_detected,
  input  logic [ADC_W-1:0] sample_value,
  output logic [7:0]       tx_data,
  output logic             tx_data_valid,
  input  logic             tx_data_ack,
  output logic             busy,
  output logic             sample_drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

`ifdef RAIN_MSG_CHECKSUM_EN
  localparam int CS_LEN = 3;
`else
  localparam int CS_LEN = 0;
`endif
  localparam int EOL_IDX  = 10 + CS_LEN;
  localparam int LINE_LEN = EOL_IDX + (EOL_CRLF ? 2 : 1);
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);
  localparam int CW = $clog2(ADC_W + 1);

  logic [1:0]       state_q, state_d;
  logic             flag_q, flag_d;
  logic [ADC_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
`ifdef RAIN_MSG_CHECKSUM_EN
  logic [7:0]       cks_q, cks_d;
`endif

  logic             ack_ok;
  logic [ADC_W-1:0] sat;
  logic [15:0]      adj;

  // Nibble to uppercase ASCII hex
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // Byte at position i of the current line
  function automatic logic [7:0] line_byte(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h0A;
    case (i)
      4'd0: r = 8'h52;
      4'd1: r = 8'h3D;
      4'd2: r = {7'b0011000, flag_q};
      4'd3: r = 8'h2C;
      4'd4: r = 8'h56;
      4'd5: r = 8'h3D;
      4'd6: r = {4'h3, bcd_q[15:12]};
      4'd7: r = {4'h3, bcd_q[11:8]};
      4'd8: r = {4'h3, bcd_q[7:4]};
      4'd9: r = {4'h3, bcd_q[3:0]};
      default: begin
`ifdef RAIN_MSG_CHECKSUM_EN
        if (i == 4'd10)      r = 8'h2A;
        else if (i == 4'd11) r = hex_ascii(cks_q[7:4]);
        else if (i == 4'd12) r = hex_ascii(cks_q[3:0]);
        else
`endif
        if (EOL_CRLF && i == 4'(EOL_IDX)) r = 8'h0D;
        else r = 8'h0A;
      end
    endcase
    return r;
  endfunction

  // Next-state logic: capture, double-dabble conversion, byte sequencing
  always_comb begin
    state_d    = state_q;
    flag_d     = flag_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
`ifdef RAIN_MSG_CHECKSUM_EN
    cks_d      = cks_q;
`endif
    drop_d = sample_valid & busy_q;
    ack_ok = tx_data_ack & tx_valid_q;

    // Values above 9999 are only representable when ADC_W >= 14
    if (32'(sample_value) > 32'd9999) sat = ADC_W'(9999);
    else sat = sample_value;

    adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5)
        adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end

    unique case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          flag_d  = rain_detected;
          bin_d   = sat;
          bcd_d   = 16'h0000;
          cnt_d   = '0;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = S_CONV;
`ifdef RAIN_MSG_CHECKSUM_EN
          cks_d   = 8'h00;
`endif
        end
      end
      S_CONV: begin
        if (cnt_q == CW'(ADC_W)) begin
          tx_data_d  = line_byte(4'd0);
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          bcd_d = {adj[14:0], bin_q[ADC_W-1]};
          bin_d = bin_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: begin
        if (ack_ok) begin
`ifdef RAIN_MSG_CHECKSUM_EN
          if (idx_q < 4'd10) cks_d = cks_q ^ tx_data_q;
`endif
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            idx_d      = 4'd0;
            state_d    = S_IDLE;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = line_byte(idx_q + 4'd1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      flag_q     <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= 16'h0000;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
`ifdef RAIN_MSG_CHECKSUM_EN
      cks_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
`ifdef RAIN_MSG_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign busy          = busy_q;
  assign sample_drop   = drop_q;

endmodule

// File: tb/tb_rain_msg_formatter.sv
// Bench for rain_msg_formatter: three instances (10-bit CRLF, 14-bit CRLF, 10-bit LF-only).
// Honours RAIN_MSG_CHECKSUM_EN when building expected lines.
module tb_rain_msg_formatter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sv   [3] = '{1'b0, 1'b0, 1'b0};
  logic       rain [3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] val0 = '0;
  logic [13:0] val1 = '0;
  logic [9:0] val2 = '0;
  logic [7:0] txd  [3];
  logic       txv  [3];
  logic       busy [3];
  logic       drop [3];
  logic       ack_m [3] = '{1'b0, 1'b0, 1'b0};
  logic       stray [3] = '{1'b0, 1'b0, 1'b0};
  logic       ack_w [3];

  int checks = 0;
  int errors = 0;
  int ack_dly = 2;
  int cnt [3] = '{0, 0, 0};
  logic [7:0] hold [3];
  int unstable = 0;
  int drops [3] = '{0, 0, 0};
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  always_comb
    for (int k = 0; k < 3; k++) ack_w[k] = ack_m[k] | stray[k];

  rain_msg_formatter #(.ADC_W(10), .EOL_CRLF(1'b1)) u0 (
    .clk(clk), .rst(rst), .sample_valid(sv[0]), .rain_detected(rain[0]),
    .sample_value(val0), .tx_data(txd[0]), .tx_data_valid(txv[0]),
    .tx_data_ack(ack_w[0]), .busy(busy[0]), .sample_drop(drop[0]));

  rain_msg_formatter #(.ADC_W(14), .EOL_CRLF(1'b1)) u1 (
    .clk(clk), .rst(rst), .sample_valid(sv[1]), .rain_detected(rain[1]),
    .sample_value(val1), .tx_data(txd[1]), .tx_data_valid(txv[1]),
    .tx_data_ack(ack_w[1]), .busy(busy[1]), .sample_drop(drop[1]));

  rain_msg_formatter #(.ADC_W(10), .EOL_CRLF(1'b0)) u2 (
    .clk(clk), .rst(rst), .sample_valid(sv[2]), .rain_detected(rain[2]),
    .sample_value(val2), .tx_data(txd[2]), .tx_data_valid(txv[2]),
    .tx_data_ack(ack_w[2]), .busy(busy[2]), .sample_drop(drop[2]));

  // UART model: ack each byte ack_dly cycles after it appears, record bytes
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ack_m[k] = 1'b0;
      if (drop[k]) drops[k] = drops[k] + 1;
      if (rst || !txv[k]) begin
        cnt[k] = 0;
      end else begin
        if (cnt[k] == 0) hold[k] = txd[k];
        else if (txd[k] !== hold[k]) unstable = unstable + 1;
        if (cnt[k] >= ack_dly) begin
          ack_m[k] = 1'b1;
          got_q.push_back(txd[k]);
          cnt[k] = 0;
        end else begin
          cnt[k] = cnt[k] + 1;
        end
      end
    end
  end

  function automatic logic [7:0] hex_c(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // Reference line builder
  function automatic void push_line(input bit f, input int v, input bit crlf);
    int s;
    logic [7:0] b [10];
    logic [7:0] cs;
    s = (v > 9999) ? 9999 : v;
    b[0] = 8'h52; b[1] = 8'h3D; b[2] = 8'h30 + 8'(f); b[3] = 8'h2C;
    b[4] = 8'h56; b[5] = 8'h3D;
    b[6] = 8'(48 + s / 1000);
    b[7] = 8'(48 + (s / 100) % 10);
    b[8] = 8'(48 + (s / 10) % 10);
    b[9] = 8'(48 + s % 10);
    cs = 8'h00;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(b[i]);
      cs = cs ^ b[i];
    end
`ifdef RAIN_MSG_CHECKSUM_EN
    exp_q.push_back(8'h2A);
    exp_q.push_back(hex_c(cs[7:4]));
    exp_q.push_back(hex_c(cs[3:0]));
`else
    if (cs == 8'hFF) cs = 8'h00;
`endif
    if (crlf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic strobe(input int k, input bit f, input int v);
    @(negedge clk); #1;
    sv[k] = 1'b1; rain[k] = f;
    if (k == 0) val0 = 10'(v);
    else if (k == 1) val1 = 14'(v);
    else val2 = 10'(v);
    @(posedge clk); #1;
    sv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int lim, output bit to);
    to = 1'b1;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (!busy[k]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (txv[0] !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", txv[0]); end
    checks++; if (txd[0] !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", txd[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy[0]); end
    checks++; if (drop[0] !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", drop[0]); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit to;
    logic [7:0] e, g;
    ack_dly = 2;
    push_line(1'b1, 523, 1'b1);
    strobe(0, 1'b1, 523);
    wait_idle(0, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL basic_byte got none want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL basic_byte got %h want %h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL basic_extra got %0d want 0", got_q.size()); got_q.delete(); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy[0]); end
  endtask

  task automatic test_digits;
    int ks [3] = '{0, 0, 1};
    int vs [3] = '{0, 1023, 12000};
    int ls [3] = '{11, 11, 15};
    int lat;
    bit to;
    logic [7:0] e, g;
    ack_dly = 0;
    for (int t = 0; t < 3; t++) begin
      push_line(1'b0, vs[t], 1'b1);
      strobe(ks[t], 1'b0, vs[t]);
      lat = 0;
      while (!txv[ks[t]] && lat < 200) begin
        @(posedge clk); #1; lat++;
      end
      checks++; if (lat != ls[t]) begin errors++; $display("FAIL digits_latency got %0d want %0d", lat, ls[t]); end
      wait_idle(ks[t], 3000, to);
      checks++; if (to) begin errors++; $display("FAIL digits_timeout got busy want idle"); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (got_q.size() == 0) begin errors++; $display("FAIL digits_byte got none want %h", e); end
        else begin
          g = got_q.pop_front();
          if (g !== e) begin errors++; $display("FAIL digits_byte got %h want %h", g, e); end
        end
      end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL digits_extra got %0d want 0", got_q.size()); got_q.delete(); end
    end
  endtask

  task automatic test_slow_ack;
    int u0;
    bit to;
    logic [7:0] e, g;
    ack_dly = 500;
    u0 = unstable;
    push_line(1'b0, 42, 1'b1);
    strobe(0, 1'b0, 42);
    wait_idle(0, 20000, to);
    checks++; if (to) begin errors++; $display("FAIL slow_timeout got busy want idle"); end
    checks++; if (unstable != u0) begin errors++; $display("FAIL slow_stable got %0d changes want 0", unstable - u0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL slow_byte got none want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL slow_byte got %h want %h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL slow_extra got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_drop;
    int d0, n;
    bit to, found;
    logic [7:0] e, g;
    ack_dly = 3;
    d0 = drops[0];
    push_line(1'b1, 314, 1'b1);
    strobe(0, 1'b1, 314);
    n = 0;
    while (!txv[0] && n < 100) begin @(posedge clk); #1; n++; end
    strobe(0, 1'b0, 555);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (ack_m[0] && got_q.size() == 12 + 3 * ((exp_q.size() > 12) ? 1 : 0)) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL drop_final_ack got none want ack"); end
    sv[0] = 1'b1; rain[0] = 1'b0; val0 = 10'd111;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    push_line(1'b0, 9, 1'b1);
    strobe(0, 1'b0, 9);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL drop_accept got %b want 1", busy[0]); end
    wait_idle(0, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL drop_timeout got busy want idle"); end
    checks++; if (drops[0] - d0 != 2) begin errors++; $display("FAIL drop_pulses got %0d want 2", drops[0] - d0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL drop_byte got none want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL drop_byte got %h want %h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL drop_extra got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_mid;
    bit to, found;
    logic [7:0] e, g;
    ack_dly = 1;
    strobe(0, 1'b1, 888);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (got_q.size() == 5) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach got %0d bytes want 5", got_q.size()); end
    rst = 1'b1;
    #1;
    checks++; if (txv[0] !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", txv[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    push_line(1'b0, 7, 1'b1);
    strobe(0, 1'b0, 7);
    wait_idle(0, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL mid_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL mid_byte got none want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL mid_byte got %h want %h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_extra got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_eol_lf;
    bit to;
    logic [7:0] e, g;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); stray[2] = 1'b1; stray[0] = 1'b1;
      @(negedge clk); stray[2] = 1'b0; stray[0] = 1'b0;
    end
    @(negedge clk);
    checks++; if (txv[2] !== 1'b0 || txv[0] !== 1'b0) begin errors++; $display("FAIL stray_valid got %b%b want 00", txv[2], txv[0]); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL stray_busy got %b want 0", busy[2]); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL stray_bytes got %0d want 0", got_q.size()); got_q.delete(); end
    ack_dly = 1;
    push_line(1'b1, 1000, 1'b0);
    strobe(2, 1'b1, 1000);
    wait_idle(2, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL lf_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL lf_byte got none want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin errors++; $display("FAIL lf_byte got %h want %h", g, e); end
      end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL lf_extra got %0d want 0", got_q.size()); got_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_digits();
    test_slow_ack();
    test_drop();
    test_reset_mid();
    test_eol_lf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
